// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - LOAD/COMPUTE/DRAIN/UNLOAD control FSM for the in-place radix-2 DIT FFT core
module fft_sequencer #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N),
  parameter int BFLY_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            log2n,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  load_we,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic                  agu_clear,
  output logic                  agu_next_step,
  input  logic [ADDR_WIDTH-1:0] agu_idx_a,
  input  logic [ADDR_WIDTH-1:0] agu_idx_b,
  output logic                  bank_sel,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr_a,
  output logic [ADDR_WIDTH-1:0] wr_addr_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_UNLOAD  = 3'd4;

  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] LAT_M1 = (ADDR_WIDTH+1)'(BFLY_LAT - 1);

  logic [2:0]            state;
  logic [2:0]            log2n_q;
  logic [2:0]            stage;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   n_val;
  logic [ADDR_WIDTH:0]   n_m1;
  logic [ADDR_WIDTH:0]   half_m1;
  logic [ADDR_WIDTH-1:0] rev;
  logic [7:0]            shamt;
  logic                  log2n_ok;

  logic                  pipe_en [BFLY_LAT];
  logic [ADDR_WIDTH-1:0] pipe_a  [BFLY_LAT];
  logic [ADDR_WIDTH-1:0] pipe_b  [BFLY_LAT];

  // One counter serves as load count, butterfly count, drain count and unload address.
  assign n_val    = ONE << log2n_q;
  assign n_m1     = n_val - ONE;
  assign half_m1  = (n_val >> 1) - ONE;
  assign log2n_ok = (log2n >= 3'd2) && (int'(log2n) <= ADDR_WIDTH);

  always_comb begin
    rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) rev[i] = cnt[ADDR_WIDTH-1-i];
  end

  // Full-width reversal shifted down so only the low log2n bits are reversed.
  assign shamt     = 8'(ADDR_WIDTH) - 8'(log2n_q);
  assign load_addr = rev >> shamt;

  assign busy          = (state != S_IDLE);
  assign in_ready      = (state == S_LOAD);
  assign load_we       = in_valid && in_ready;
  assign agu_clear     = (state == S_IDLE) || (state == S_LOAD);
  assign rd_en         = (state == S_COMPUTE);
  assign agu_next_step = rd_en;
  assign rd_addr_a     = agu_idx_a;
  assign rd_addr_b     = agu_idx_b;
  assign wr_en         = pipe_en[BFLY_LAT-1];
  assign wr_addr_a     = pipe_a[BFLY_LAT-1];
  assign wr_addr_b     = pipe_b[BFLY_LAT-1];
  assign out_valid     = (state == S_UNLOAD);
  assign out_addr      = cnt[ADDR_WIDTH-1:0];
  assign out_last      = out_valid && (cnt == n_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      log2n_q  <= '0;
      stage    <= '0;
      cnt      <= '0;
      bank_sel <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        pipe_en[i] <= 1'b0;
        pipe_a[i]  <= '0;
        pipe_b[i]  <= '0;
      end
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      pipe_en[0] <= rd_en;
      pipe_a[0]  <= agu_idx_a;
      pipe_b[0]  <= agu_idx_b;
      for (int i = 1; i < BFLY_LAT; i++) begin
        pipe_en[i] <= pipe_en[i-1];
        pipe_a[i]  <= pipe_a[i-1];
        pipe_b[i]  <= pipe_b[i-1];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (log2n_ok) begin
              log2n_q  <= log2n;
              bank_sel <= 1'b0;
              stage    <= '0;
              cnt      <= '0;
              state    <= S_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == n_m1) begin
              cnt   <= '0;
              state <= S_COMPUTE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        S_COMPUTE: begin
          if (cnt == half_m1) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DRAIN: begin
          // Final drain cycle carries the stage's last write-back, so banks swap on its edge.
          if (cnt == LAT_M1) begin
            cnt      <= '0;
            bank_sel <= ~bank_sel;
            stage    <= stage + 3'd1;
            state    <= (stage + 3'd1 == log2n_q) ? S_UNLOAD : S_COMPUTE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (cnt == n_m1) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - directed table-driven bench for fft_sequencer
module tb_fft_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] log2n;
  logic       busy, done, cfg_err;
  logic       in_valid, in_ready, load_we;
  logic [4:0] load_addr;
  logic       agu_clear, agu_next_step;
  logic [4:0] agu_idx_a, agu_idx_b;
  logic       bank_sel, rd_en, wr_en;
  logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic       out_valid, out_ready, out_last;
  logic [4:0] out_addr;

  int total = 0;
  int bad   = 0;

  fft_sequencer #(.MAX_N(32), .BFLY_LAT(3)) dut (
    .clk(clk), .reset(reset), .start(start), .log2n(log2n),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .load_we(load_we), .load_addr(load_addr),
    .agu_clear(agu_clear), .agu_next_step(agu_next_step),
    .agu_idx_a(agu_idx_a), .agu_idx_b(agu_idx_b),
    .bank_sel(bank_sel), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    int l2;
    bit gaps;
    int exp_cycles;
    int exp_bank;
  } run_t;

  typedef struct {
    int l2;
    int exp_err;
  } cfg_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitrev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic do_start(input int l2);
    @(negedge clk);
    start = 1'b1;
    log2n = 3'(l2);
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic do_load(input int l2, input bit gaps);
    int n, k, guard;
    n = 1 << l2;
    k = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (guard == 3);
      log2n    = (l2 == 2) ? 3'd3 : 3'd2;
      #1;
      check("in_ready_load", in_ready, 1);
      check("load_we", load_we, in_valid);
      if (in_valid) begin
        check("load_addr", load_addr, bitrev(k, l2));
        k++;
      end
    end
    if (k < n) check("load_timeout", k, n);
  endtask

  task automatic run_fft(input int l2, input bit gaps, input int exp_cyc, input int exp_bank);
    int n, half, cyc, rdn, idx, guard;
    bit         rdh [512];
    logic [4:0] ah  [512];
    logic [4:0] bh  [512];
    n    = 1 << l2;
    half = n / 2;
    do_start(l2);
    check("busy_after_start", busy, 1);
    check("agu_clear_load", agu_clear, 1);
    check("load_addr_first", load_addr, 0);
    do_load(l2, gaps);

    cyc = 0;
    rdn = 0;
    while (cyc < 400) begin
      @(negedge clk);
      in_valid  = 1'b0;
      start     = 1'b0;
      log2n     = 3'd1;
      agu_idx_a = 5'($urandom_range(0, 31));
      agu_idx_b = 5'($urandom_range(0, 31));
      #1;
      if (out_valid) break;
      rdh[cyc] = rd_en;
      ah[cyc]  = rd_addr_a;
      bh[cyc]  = rd_addr_b;
      check("rd_addr_a", rd_addr_a, agu_idx_a);
      check("rd_addr_b", rd_addr_b, agu_idx_b);
      check("next_step", agu_next_step, rd_en);
      check("agu_clear_run", agu_clear, 0);
      check("in_ready_run", in_ready, 0);
      check("wr_en", wr_en, (cyc >= 3) ? int'(rdh[cyc-3]) : 0);
      if (cyc >= 3 && rdh[cyc-3]) begin
        check("wr_addr_a", wr_addr_a, ah[cyc-3]);
        check("wr_addr_b", wr_addr_b, bh[cyc-3]);
      end
      if (rd_en) begin
        check("bank_sel_stage", bank_sel, (rdn / half) % 2);
        rdn++;
      end
      cyc++;
    end
    check("compute_cycles", cyc, exp_cyc);
    check("rd_count", rdn, half * l2);

    idx = 0;
    guard = 0;
    while (idx < n && guard < 400) begin
      @(negedge clk);
      guard++;
      out_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (guard == 2);
      log2n     = 3'd3;
      #1;
      check("out_valid", out_valid, 1);
      check("bank_final", bank_sel, exp_bank);
      check("out_addr", out_addr, idx);
      check("out_last", out_last, (idx == n - 1) ? 1 : 0);
      if (out_ready) idx++;
    end
    if (idx < n) check("unload_timeout", idx, n);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("busy_idle", busy, 0);
    check("out_valid_idle", out_valid, 0);
    @(negedge clk);
    #1;
    check("done_cleared", done, 0);
  endtask

  run_t runs [4];
  cfg_t cfgs [4];

  initial begin
    int rdn, guard;
    runs[0] = '{l2: 2, gaps: 1'b0, exp_cycles: 10, exp_bank: 0};
    runs[1] = '{l2: 3, gaps: 1'b1, exp_cycles: 21, exp_bank: 1};
    runs[2] = '{l2: 4, gaps: 1'b0, exp_cycles: 44, exp_bank: 0};
    runs[3] = '{l2: 5, gaps: 1'b0, exp_cycles: 95, exp_bank: 1};
    cfgs[0] = '{l2: 1, exp_err: 1};
    cfgs[1] = '{l2: 6, exp_err: 1};
    cfgs[2] = '{l2: 7, exp_err: 1};
    cfgs[3] = '{l2: 0, exp_err: 1};

    reset = 1'b1; start = 1'b0; log2n = 3'd0; in_valid = 1'b0; out_ready = 1'b0;
    agu_idx_a = 5'd0; agu_idx_b = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_agu_clear", agu_clear, 1);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_load_addr", load_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_start(cfgs[i].l2);
      check("cfg_err_pulse", cfg_err, cfgs[i].exp_err);
      check("cfg_busy", busy, 0);
      check("cfg_in_ready", in_ready, 0);
      @(negedge clk);
      #1;
      check("cfg_err_clear", cfg_err, 0);
      check("cfg_busy_after", busy, 0);
    end

    for (int i = 0; i < 4; i++)
      run_fft(runs[i].l2, runs[i].gaps, runs[i].exp_cycles, runs[i].exp_bank);

    do_start(4);
    do_load(4, 1'b0);
    rdn = 0;
    guard = 0;
    while (rdn < 18 && guard < 200) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b0;
      start    = 1'b0;
      #1;
      if (rd_en) rdn++;
    end
    check("reach_stage2", rdn, 18);
    check("stage2_bank", bank_sel, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_agu_clear", agu_clear, 1);
    check("mid_rst_bank", bank_sel, 0);
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_out_valid", out_valid, 0);
    for (int c = 0; c < 5; c++) begin
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_done", done, 0);
      @(negedge clk);
      #1;
    end
    run_fft(3, 1'b1, 21, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
